// File: rtl/grf_read_hazard.sv
// Decode-stage GRF read side: three-slot (E/M/W) producer scoreboard with
// stall detection, operand bypass from the E/M/W result buses, and a stall counter.
module grf_read_hazard #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rs_d,
    input  logic [4:0]        rt_d,
    input  logic [1:0]        tuse_rs,
    input  logic [1:0]        tuse_rt,
    input  logic [4:0]        dst_d,
    input  logic [1:0]        tnew_d,
    input  logic [DATA_W-1:0] wd_e,
    input  logic [DATA_W-1:0] wd_m,
    input  logic [DATA_W-1:0] wd_w,
    input  logic [DATA_W-1:0] grf_rd1,
    input  logic [DATA_W-1:0] grf_rd2,
    output logic [4:0]        grf_a1,
    output logic [4:0]        grf_a2,
    output logic [DATA_W-1:0] rs_val,
    output logic [DATA_W-1:0] rt_val,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [4:0] e_dst, m_dst, w_dst;
    logic [1:0] e_tnew, m_tnew, w_tnew;
    logic [2:0] rs_res, rt_res;

    function automatic logic [1:0] dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Returns {stall, source}; source 0 = GRF, 1 = E, 2 = M, 3 = W.
    function automatic logic [2:0] resolve(
        input logic [4:0] r,  input logic [1:0] tuse,
        input logic [4:0] ed, input logic [1:0] et,
        input logic [4:0] md, input logic [1:0] mt,
        input logic [4:0] wd, input logic [1:0] wt
    );
        logic       hit;
        logic [1:0] t;
        logic [1:0] src;
        hit = 1'b0;
        t   = '0;
        src = 2'd0;
        if (r != 5'd0 && tuse != 2'd3) begin
            if (ed == r) begin
                hit = 1'b1; t = et; src = 2'd1;
            end else if (md == r) begin
                hit = 1'b1; t = mt; src = 2'd2;
            end else if (wd == r) begin
                hit = 1'b1; t = wt; src = 2'd3;
            end
        end
        return {hit && (t > tuse), (hit && t == 2'd0) ? src : 2'd0};
    endfunction

    function automatic logic [DATA_W-1:0] pick(
        input logic [1:0] src, input logic [DATA_W-1:0] grf,
        input logic [DATA_W-1:0] ve, input logic [DATA_W-1:0] vm,
        input logic [DATA_W-1:0] vw
    );
        case (src)
            2'd1:    return ve;
            2'd2:    return vm;
            2'd3:    return vw;
            default: return grf;
        endcase
    endfunction

    always_comb begin
        rs_res = resolve(rs_d, tuse_rs, e_dst, e_tnew, m_dst, m_tnew, w_dst, w_tnew);
        rt_res = resolve(rt_d, tuse_rt, e_dst, e_tnew, m_dst, m_tnew, w_dst, w_tnew);
        stall  = rs_res[2] | rt_res[2];
        rs_val = pick(rs_res[1:0], grf_rd1, wd_e, wd_m, wd_w);
        rt_val = pick(rt_res[1:0], grf_rd2, wd_e, wd_m, wd_w);
        grf_a1 = rs_d;
        grf_a2 = rt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_dst     <= '0;
            e_tnew    <= '0;
            m_dst     <= '0;
            m_tnew    <= '0;
            w_dst     <= '0;
            w_tnew    <= '0;
            stall_cnt <= '0;
        end else begin
            w_dst  <= m_dst;
            w_tnew <= dec(m_tnew);
            m_dst  <= e_dst;
            m_tnew <= dec(e_tnew);
            e_dst  <= stall ? 5'd0 : dst_d;
            e_tnew <= stall ? 2'd0 : tnew_d;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_grf_read_hazard.sv
// Scoreboard bench for grf_read_hazard: a driver predicts each cycle from a list
// of in-flight producers tagged by issue cycle; a negedge monitor compares.
module tb_grf_read_hazard;

    localparam int CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_d, rt_d, dst_d;
    logic [1:0]  tuse_rs, tuse_rt, tnew_d;
    logic [31:0] wd_e, wd_m, wd_w, grf_rd1, grf_rd2;
    logic [4:0]  grf_a1, grf_a2;
    logic [31:0] rs_val, rt_val;
    logic        stall;
    logic [1:0]  stall_cnt;

    grf_read_hazard #(.DATA_W(32), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
        .dst_d(dst_d), .tnew_d(tnew_d),
        .wd_e(wd_e), .wd_m(wd_m), .wd_w(wd_w),
        .grf_rd1(grf_rd1), .grf_rd2(grf_rd2),
        .grf_a1(grf_a1), .grf_a2(grf_a2),
        .rs_val(rs_val), .rt_val(rt_val),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] dst;
        int         tnew;
        int         issued;
    } prod_t;

    typedef struct {
        string       tag;
        logic        stl;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [4:0]  a1;
        logic [4:0]  a2;
        int          cnt;
    } exp_t;

    prod_t inflight[$];
    exp_t  sbq[$];
    int    now_cyc   = 0;
    int    cnt_model = 0;
    int    vectors     = 0;
    int    miscompares = 0;

    // Newest producer (age 0 = in E) that writes r decides; remaining latency
    // is its tnew minus its age since entering E.
    function automatic void predict(input logic [4:0] r, input logic [1:0] tuse,
                                    input logic [31:0] grf,
                                    output logic stl, output logic [31:0] val);
        int age, rem;
        stl = 1'b0;
        val = grf;
        if (r == 5'd0 || tuse == 2'd3) return;
        for (int i = inflight.size() - 1; i >= 0; i--) begin
            age = now_cyc - inflight[i].issued;
            if (age > 2) break;
            if (inflight[i].dst == r) begin
                rem = inflight[i].tnew - age;
                if (rem < 0) rem = 0;
                if (rem > int'(tuse)) stl = 1'b1;
                else if (rem == 0) val = (age == 0) ? wd_e : (age == 1) ? wd_m : wd_w;
                return;
            end
        end
    endfunction

    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] ur, input logic [1:0] ut,
                        input logic [4:0] dst, input logic [1:0] tn, input string tag);
        exp_t        e;
        prod_t       p;
        logic        s1, s2;
        logic [31:0] v1, v2;
        reset   = rst;
        rs_d    = rs;
        rt_d    = rt;
        tuse_rs = ur;
        tuse_rt = ut;
        dst_d   = dst;
        tnew_d  = tn;
        wd_e    = $urandom;
        wd_m    = $urandom;
        wd_w    = $urandom;
        grf_rd1 = (rs == 5'd0) ? 32'd0 : $urandom;
        grf_rd2 = (rt == 5'd0) ? 32'd0 : $urandom;
        predict(rs, ur, grf_rd1, s1, v1);
        predict(rt, ut, grf_rd2, s2, v2);
        e.tag = tag;
        e.stl = s1 | s2;
        e.rsv = v1;
        e.rtv = v2;
        e.a1  = rs;
        e.a2  = rt;
        e.cnt = cnt_model;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        now_cyc++;
        if (rst) begin
            inflight.delete();
            cnt_model = 0;
        end else begin
            if (!e.stl) begin
                p.dst    = dst;
                p.tnew   = int'(tn);
                p.issued = now_cyc;
                inflight.push_back(p);
            end
            if (e.stl && cnt_model < CNT_MAX) cnt_model++;
        end
        while (inflight.size() > 3) void'(inflight.pop_front());
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (stall !== e.stl || rs_val !== e.rsv || rt_val !== e.rtv ||
                grf_a1 !== e.a1 || grf_a2 !== e.a2 || stall_cnt !== 2'(e.cnt)) begin
                miscompares++;
                $display("FAIL %s: got stall=%b rs_val=%h rt_val=%h a1=%0d a2=%0d cnt=%0d, want stall=%b rs_val=%h rt_val=%h a1=%0d a2=%0d cnt=%0d",
                         e.tag, stall, rs_val, rt_val, grf_a1, grf_a2, stall_cnt,
                         e.stl, e.rsv, e.rtv, e.a1, e.a2, e.cnt);
            end
        end
    end

    initial begin
        reset = 1'b1;
        {rs_d, rt_d, dst_d} = '0;
        {tuse_rs, tuse_rt, tnew_d} = '0;
        {wd_e, wd_m, wd_w, grf_rd1, grf_rd2} = '0;
        repeat (2) @(posedge clk);
        #1;

        step(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, "reset_cycle");
        step(1'b0, 5'd5, 5'd5, 2'd0, 2'd0, 5'd0, 2'd0, "after_reset");

        // Load-use: two stall cycles, then forward from W.
        step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, "lu_issue");
        step(1'b0, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, "lu_stall1");
        step(1'b0, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, "lu_stall2");
        step(1'b0, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, "lu_fwd_w");

        step(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, "alu_reset");
        step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, "alu_issue");
        step(1'b0, 5'd0, 5'd3, 2'd3, 2'd1, 5'd0, 2'd0, "alu_tuse1");
        step(1'b0, 5'd0, 5'd3, 2'd3, 2'd0, 5'd0, 2'd0, "alu_fwd_m");

        step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, "prio_first");
        step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, "prio_second");
        step(1'b0, 5'd4, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, "prio_e_wins");

        step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, "zero_issue");
        step(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, "zero_use");
        step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2, "unused_issue");
        step(1'b0, 5'd9, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, "unused_use");

        // Saturation: six stalled cycles into a 2-bit counter.
        step(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, "sat_reset");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2, "sat_issue");
            step(1'b0, 5'd7, 5'd7, 2'd0, 2'd0, 5'd0, 2'd0, "sat_stall_a");
            step(1'b0, 5'd7, 5'd7, 2'd0, 2'd0, 5'd0, 2'd0, "sat_stall_b");
        end
        step(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2, "mid_issue");
        step(1'b1, 5'd7, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, "mid_reset");
        step(1'b0, 5'd7, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, "mid_after");

        repeat (500) begin
            step($urandom_range(0, 49) == 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), "random");
        end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses left, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
